serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: computes A - B one bit per clock, LSB first,

---
 rtl/serial_subtractor_if.sv | 36 +++
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for serial_subtractor.
// Carries ovf only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow, ovf
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow, ovf
   );
`else
   modport master (
      output start, a, b,
      input  busy, done, diff, borrow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow
   );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell and a borrow flop.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_subtractor_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] r_sr;
   logic [CW-1:0]    cnt;
   logic             bw;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;

   logic             d_bit;
   logic             bw_nxt;
   logic             last;
   logic [WIDTH-1:0] r_cat;

   assign d_bit  = a_sr[0] ^ b_sr[0] ^ bw;
   assign bw_nxt = (~a_sr[0] & b_sr[0])
                 | (~(a_sr[0] ^ b_sr[0]) & bw);
   assign last   = (cnt == CW'(WIDTH - 1));
   // new bit enters at the MSB; at completion this is the whole result
   assign r_cat  = {d_bit, r_sr};

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb;
   logic b_msb;
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (state != S_RUN && bus.start) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
         end
         if (state == S_RUN && last)
            ovf_q <= (a_msb != b_msb) && (d_bit != a_msb);
      end
   end

   assign bus.ovf = ovf_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         r_sr     <= '0;
         cnt      <= '0;
         bw       <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  a_sr  <= bus.a;
                  b_sr  <= bus.b;
                  r_sr  <= '0;
                  cnt   <= '0;
                  bw    <= 1'b0;
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               r_sr <= r_cat[WIDTH-1:1];
               bw   <= bw_nxt;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  diff_q   <= r_cat;
                  borrow_q <= bw_nxt;
                  state    <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy   = (state == S_RUN);
   assign bus.done   = (state == S_DONE);
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, corner
// sequences and random back-to-back operations against an arithmetic model.
module tb_serial_subtractor;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] d;
      logic         bw;
      logic         ov;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic ref_model(input logic [W-1:0] a,
                            input logic [W-1:0] b,
                            output logic [W-1:0] d,
                            output logic bw,
                            output logic ov);
      int u;
      int s;
      u  = int'(a) - int'(b);
      s  = int'($signed(a)) - int'($signed(b));
      d  = u[W-1:0];
      bw = (u < 0);
      ov = (s > 127) || (s < -128);
   endtask

   task automatic chk_ovf(input string nm, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
      chk(nm, 32'(bus.ovf), 32'(exp));
`else
      if (exp === 1'bx) chk(nm, 32'(bus.borrow), 32'(exp));
`endif
   endtask

   task automatic op(input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input bit inject,
                     input logic [W-1:0] ed,
                     input logic eb,
                     input logic eo,
                     input string tag);
      logic [W-1:0] pd;
      logic         pb;
      int           k;
      bit           seen;
      pd = bus.diff;
      pb = bus.borrow;
      bus.a = a;
      bus.b = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
      seen = 1'b0;
      for (k = 1; k <= W + 4; k++) begin
         if (inject && k == 3) begin
            bus.start = 1'b1;
            bus.a = ~a;
            bus.b = b + 1'b1;
         end
         if (inject && k == 5) bus.start = 1'b0;
         @(posedge clk);
         #1;
         if (k == W / 2)
            chk({tag, ".stable"}, 32'({bus.diff, bus.borrow}),
                32'({pd, pb}));
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, ".latency"}, seen ? 32'(k) : 32'd0, 32'(W));
      chk({tag, ".diff"}, 32'(bus.diff), 32'(ed));
      chk({tag, ".borrow"}, 32'(bus.borrow), 32'(eb));
      chk_ovf({tag, ".ovf"}, eo);
   endtask

   initial begin
      vec_t         tbl [4];
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] rd;
      logic         rbw;
      logic         rov;
      bit           seen;

      tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
      tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
      tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      tbl[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      #12;
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.done", 32'(bus.done), 32'd0);
      chk("rst.diff", 32'(bus.diff), 32'd0);
      chk("rst.borrow", 32'(bus.borrow), 32'd0);
      chk_ovf("rst.ovf", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 4; i++) begin
         op(tbl[i].a, tbl[i].b, 1'b0, tbl[i].d, tbl[i].bw,
            tbl[i].ov, $sformatf("vec%0d", i));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.pulse", i), 32'(bus.done), 32'd0);
         chk($sformatf("vec%0d.idle", i), 32'(bus.busy), 32'd0);
      end

      op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b0, 1'b0, "inject");
      @(posedge clk);
      #1;

      bus.a = 8'h55;
      bus.b = 8'h11;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst.busy", 32'(bus.busy), 32'd0);
      chk("midrst.done", 32'(bus.done), 32'd0);
      chk("midrst.diff", 32'(bus.diff), 32'd0);
      chk("midrst.borrow", 32'(bus.borrow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (W + 2) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      chk("midrst.nodone", 32'(seen), 32'd0);
      chk("midrst.held", 32'(bus.diff), 32'd0);
      op(8'h09, 8'h09, 1'b0, 8'h00, 1'b0, 1'b0, "after_rst");

      for (int n = 0; n < 1000; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         ref_model(ra, rb, rd, rbw, rov);
         op(ra, rb, 1'b0, rd, rbw, rov, $sformatf("rnd%0d", n));
         if (n % 7 == 6) begin
            @(posedge clk);
            #1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
